// File: rtl/charmatrix_scroller.sv
`timescale 1ns/1ps
// Character-matrix renderer: buffers received characters with a color index in a
// ring buffer and streams a NUM_CHARS window as glyph pixels once per refresh period.
module charmatrix_scroller #(
   parameter int NUM_CHARS      = 4,
   parameter int BUF_DEPTH      = 8,
   parameter int CHAR_W         = 5,
   parameter int CHAR_H         = 7,
   parameter int COLOR_BITS     = 4,
   parameter int REFRESH_CYCLES = 262144,
   parameter int SCROLL_DIV     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   input  logic [COLOR_BITS-1:0]    rnd_color,
   output logic [7:0]               char_addr,
   input  logic [CHAR_W*CHAR_H-1:0] char_data,
   output logic [COLOR_BITS-1:0]    color_addr,
   input  logic [23:0]              color_data,
   output logic [23:0]              pix_data,
   output logic                     pix_valid,
   input  logic                     pix_ready,
   output logic                     pix_latch,
   output logic                     busy
);
   localparam int PIX = CHAR_W * CHAR_H;
   localparam int AW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int LW  = (PIX > 1) ? $clog2(PIX) : 1;
   localparam int CW  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
   localparam int RW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int FW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

   state_t                state, state_n;
   logic [7:0]            char_mem [BUF_DEPTH];
   logic [COLOR_BITS-1:0] col_mem  [BUF_DEPTH];
   logic [AW-1:0]         wr_ptr, scroll_off, off_next, base, base_q, nxt_slot, clr_idx;
   logic [AW:0]           count, off_inc;
   logic                  rand_mode, scroll_en, clr_active;
   logic [COLOR_BITS-1:0] fixed_idx;
   logic [RW-1:0]         ref_cnt;
   logic [FW-1:0]         frame_cnt;
   logic [LW-1:0]         led_idx;
   logic [CW-1:0]         char_idx;
   logic                  tick, rx_fire, last_pix, frame_start, frame_done;

   assign tick     = (ref_cnt == RW'(REFRESH_CYCLES - 1));
   assign rx_fire  = rx_valid & rx_ready;
   assign last_pix = (char_idx == CW'(NUM_CHARS - 1)) && (led_idx == LW'(PIX - 1));
   assign nxt_slot = base_q + AW'(char_idx) + AW'(1);

   // Scroll mode starts at the oldest stored character; otherwise the newest ends the window
   assign base = scroll_en ? (wr_ptr - AW'(count) + scroll_off)
                           : (wr_ptr - AW'(NUM_CHARS % BUF_DEPTH));

   assign off_inc  = {1'b0, scroll_off} + (AW+1)'(1);
   assign off_next = ((count <= (AW+1)'(NUM_CHARS)) || (off_inc >= count)) ? '0 : off_inc[AW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ref_cnt <= '0;
      else if (tick) ref_cnt <= '0;
      else ref_cnt <= ref_cnt + RW'(1);
   end

   // Write side: byte decode, ring-buffer writes, clear sweep and marquee offset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            char_mem[i] <= 8'h20;
            col_mem[i]  <= '0;
         end
         wr_ptr     <= '0;
         count      <= '0;
         scroll_off <= '0;
         rand_mode  <= 1'b1;
         fixed_idx  <= '0;
         scroll_en  <= 1'b0;
         clr_active <= 1'b0;
         clr_idx    <= '0;
         rx_ready   <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         if (frame_done) begin
            if (frame_cnt == FW'(SCROLL_DIV - 1)) begin
               frame_cnt <= '0;
               if (scroll_en) scroll_off <= off_next;
            end else begin
               frame_cnt <= frame_cnt + FW'(1);
            end
         end
         if (clr_active) begin
            char_mem[clr_idx] <= 8'h20;
            col_mem[clr_idx]  <= '0;
            clr_idx           <= clr_idx + AW'(1);
            if (clr_idx == AW'(BUF_DEPTH - 1)) begin
               clr_active <= 1'b0;
               rx_ready   <= 1'b1;
               wr_ptr     <= '0;
               count      <= '0;
               scroll_off <= '0;
            end
         end else begin
            rx_ready <= 1'b1;
            if (rx_fire) begin
               if (rx_data == 8'h00) begin
                  clr_active <= 1'b1;
                  clr_idx    <= '0;
                  rx_ready   <= 1'b0;
               end else if (rx_data == 8'h01) begin
                  rand_mode <= 1'b1;
               end else if (rx_data == 8'h02) begin
                  scroll_en  <= ~scroll_en;
                  scroll_off <= '0;
               end else if (rx_data[7:4] == 4'h1) begin
                  rand_mode <= 1'b0;
                  fixed_idx <= COLOR_BITS'(rx_data);
               end else if (rx_data >= 8'h20) begin
                  char_mem[wr_ptr] <= rx_data;
                  col_mem[wr_ptr]  <= rand_mode ? rnd_color : fixed_idx;
                  wr_ptr           <= wr_ptr + AW'(1);
                  if (count != (AW+1)'(BUF_DEPTH)) count <= count + (AW+1)'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n     = state;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      case (state)
         S_IDLE: if (tick && !busy) begin
            state_n     = S_LOAD;
            frame_start = 1'b1;
         end
         S_LOAD: state_n = S_SEND;
         S_SEND: if (pix_ready) begin
            state_n    = last_pix ? S_IDLE : S_LOAD;
            frame_done = last_pix;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Render side: addresses are registered so the ROM data settles during LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= 1'b0;
         pix_valid  <= 1'b0;
         pix_data   <= '0;
         pix_latch  <= 1'b0;
         char_addr  <= '0;
         color_addr <= '0;
         base_q     <= '0;
         char_idx   <= '0;
         led_idx    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               busy <= frame_start;
               if (frame_start) begin
                  base_q     <= base;
                  char_idx   <= '0;
                  led_idx    <= '0;
                  char_addr  <= char_mem[base];
                  color_addr <= col_mem[base];
               end
            end
            S_LOAD: begin
               pix_valid <= 1'b1;
               pix_data  <= char_data[led_idx] ? color_data : 24'h0;
               pix_latch <= last_pix;
            end
            S_SEND: if (pix_ready) begin
               pix_valid <= 1'b0;
               pix_data  <= '0;
               pix_latch <= 1'b0;
               if (!last_pix) begin
                  if (led_idx == LW'(PIX - 1)) begin
                     led_idx    <= '0;
                     char_idx   <= char_idx + CW'(1);
                     char_addr  <= char_mem[nxt_slot];
                     color_addr <= col_mem[nxt_slot];
                  end else begin
                     led_idx <= led_idx + LW'(1);
                  end
               end
            end
            default: busy <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_charmatrix_scroller.sv
`timescale 1ns/1ps
// Directed bench for charmatrix_scroller: external glyph/color ROM models, a pixel
// capture monitor and a linear sequence of hand-computed frame expectations.
module tb_charmatrix_scroller;
   localparam int NC = 4, BD = 8, CWD = 5, CHT = 7, CB = 4, RC = 300, SD = 2;
   localparam int PIX = CWD * CHT, FP = NC * PIX;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic [7:0]    rx_data;
   logic          rx_valid, rx_ready;
   logic [CB-1:0] rnd_color;
   logic [7:0]    char_addr;
   logic [PIX-1:0] char_data;
   logic [CB-1:0] color_addr;
   logic [23:0]   color_data, pix_data;
   logic          pix_valid, pix_ready, pix_latch, busy;

   int errors = 0, checks = 0;
   int cap_n = 0, frame_len = 0, frames_done = 0, cyc = 0;
   logic [23:0]   cap_data [FP];
   logic [7:0]    cap_ch   [FP];
   logic [CB-1:0] cap_col  [FP];
   logic          cap_lat  [FP];

   function automatic logic [PIX-1:0] glyph(input logic [7:0] a);
      return {a[2:0], a, a, a, a};
   endfunction

   function automatic logic [23:0] color(input logic [CB-1:0] c);
      return {4'h8, c, 4'h2, c, 4'h1, ~c};
   endfunction

   assign char_data  = glyph(char_addr);
   assign color_data = color(color_addr);

   charmatrix_scroller #(
      .NUM_CHARS(NC), .BUF_DEPTH(BD), .CHAR_W(CWD), .CHAR_H(CHT), .COLOR_BITS(CB),
      .REFRESH_CYCLES(RC), .SCROLL_DIV(SD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rnd_color(rnd_color), .char_addr(char_addr), .char_data(char_data),
      .color_addr(color_addr), .color_data(color_data), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_latch(pix_latch), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         cap_n = 0;
         frames_done = 0;
      end else if (pix_valid && pix_ready) begin
         if (cap_n < FP) begin
            cap_data[cap_n] = pix_data;
            cap_ch[cap_n]   = char_addr;
            cap_col[cap_n]  = color_addr;
            cap_lat[cap_n]  = pix_latch;
         end
         if (pix_latch) begin
            frame_len = cap_n + 1;
            cap_n = 0;
            frames_done++;
         end else begin
            cap_n++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      @(posedge clk); #1;
      rx_data = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (rx_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'(ok), 1);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_busy(input logic v, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== v && n < 2000);
      if (busy !== v) chk(tag, 32'(busy), 32'(v));
   endtask

   task automatic next_frame();
      wait_busy(1'b0, "idle_timeout");
      wait_busy(1'b1, "start_timeout");
      cap_n = 0;
      frame_len = 0;
      wait_busy(1'b0, "end_timeout");
   endtask

   task automatic check_frame(input string tag, input logic [31:0] chars, input logic [15:0] cols);
      logic [7:0]     c;
      logic [CB-1:0]  ci;
      logic [PIX-1:0] g;
      logic [23:0]    e;
      int bad, nl;
      chk($sformatf("%s_len", tag), frame_len, FP);
      for (int p = 0; p < NC; p++) begin
         c  = chars[8*p +: 8];
         ci = cols[4*p +: 4];
         g  = glyph(c);
         bad = 0;
         chk($sformatf("%s_ch%0d", tag, p), cap_ch[p*PIX], c);
         chk($sformatf("%s_col%0d", tag, p), cap_col[p*PIX], ci);
         for (int l = 0; l < PIX; l++) begin
            e = g[l] ? color(ci) : 24'h0;
            if (cap_data[p*PIX+l] !== e) bad++;
         end
         chk($sformatf("%s_pix%0d", tag, p), bad, 0);
      end
      nl = 0;
      for (int k = 0; k < FP; k++) if (cap_lat[k] === 1'b1) nl++;
      chk($sformatf("%s_latch_cnt", tag), nl, 1);
      chk($sformatf("%s_latch_last", tag), 32'(cap_lat[FP-1]), 1);
   endtask

   initial begin
      logic [7:0]  slots [BD];
      logic [31:0] obs, exp;
      logic [23:0] hold_d;
      logic        hold_v;
      int exp_off, lowcnt, changes, t0, n;
      bit seen;

      rx_valid = 1'b0; rx_data = 8'h00; rnd_color = '0; pix_ready = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", 32'(rx_ready), 0);
      chk("rst_pix_valid", 32'(pix_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_pix_latch", 32'(pix_latch), 0);
      chk("rst_char_addr", char_addr, 0);
      chk("rst_color_addr", color_addr, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rx_ready_pre_edge", 32'(rx_ready), 0);
      @(negedge clk);
      chk("rx_ready_rise", 32'(rx_ready), 1);

      // tick to first pixel latency
      wait_busy(1'b1, "first_start");
      chk("load_no_valid", 32'(pix_valid), 0);
      chk("load_char_space", char_addr, 8'h20);
      @(negedge clk);
      chk("first_valid", 32'(pix_valid), 1);

      // random colors
      rnd_color = 4'd3;
      send_str("ABCD");
      next_frame();
      check_frame("abcd", "DCBA", 16'h3333);

      // fixed color 5, then back to random
      send_byte(8'h15);
      rnd_color = 4'd12;
      send_str("WXYZ");
      next_frame();
      check_frame("wxyz", "ZYXW", 16'h5555);
      send_byte(8'h01);
      rnd_color = 4'd9;
      send_str("Q");
      next_frame();
      check_frame("q", "QZYX", 16'h9555);

      // clear: rx_ready low for BUF_DEPTH cycles, byte offered meanwhile is ignored
      send_byte(8'h00);
      rx_data = "K";
      rx_valid = 1'b1;
      lowcnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (rx_ready) seen = 1'b1;
         else lowcnt++;
         if (i == 4) rx_valid = 1'b0;
      end
      chk("clr_low_cycles", lowcnt, BD);
      next_frame();
      check_frame("clr", "    ", 16'h0000);

      // ten characters into an 8-deep buffer
      rnd_color = 4'd7;
      send_str("0123456789");
      next_frame();
      check_frame("wrap", "9876", 16'h7777);

      // marquee: oldest-first base advancing every SD frames, wrapping after 8 steps
      slots = '{"8", "9", "2", "3", "4", "5", "6", "7"};
      send_byte(8'h02);
      exp_off = 0;
      for (int k = 0; k < 18; k++) begin
         next_frame();
         for (int p = 0; p < NC; p++) begin
            obs[8*p +: 8] = cap_ch[p*PIX];
            exp[8*p +: 8] = slots[(2 + exp_off + p) % BD];
         end
         chk($sformatf("scroll_f%0d", k), obs, exp);
         if (frames_done % SD == 0) exp_off = (exp_off + 1) % BD;
      end

      // stall across a refresh tick: outputs hold, tick dropped, frame intact
      send_byte(8'h02);
      wait_busy(1'b0, "stall_idle");
      wait_busy(1'b1, "stall_start");
      t0 = cyc;
      cap_n = 0;
      frame_len = 0;
      n = 0;
      while (cap_n < 130 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1 pix_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      hold_d = pix_data;
      hold_v = pix_valid;
      changes = 0;
      repeat (48) begin
         @(negedge clk);
         if (pix_data !== hold_d || pix_valid !== hold_v || pix_latch !== 1'b0) changes++;
      end
      @(posedge clk); #1 pix_ready = 1'b1;
      chk("stall_valid", 32'(hold_v), 1);
      chk("stall_stable", changes, 0);
      wait_busy(1'b0, "stall_end");
      check_frame("stall", "9876", 16'h7777);
      wait_busy(1'b1, "after_stall_start");
      chk("tick_dropped_gap", cyc - t0, 2 * RC);

      // asynchronous reset mid-frame
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pix_valid !== 1'b1 && n < 20);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pix_valid", 32'(pix_valid), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_pix_latch", 32'(pix_latch), 0);
      chk("arst_rx_ready", 32'(rx_ready), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/charmatrix_scroller.md
# charmatrix_scroller

Parametrised successor to the single-window character matrix controller. It accepts a byte stream from the UART receiver over valid/ready and stores printable characters with a per-character color index in a ring buffer. Control bytes handle clear, color mode and scroll mode. Once per refresh period it renders a window of NUM_CHARS characters into CHAR_W×CHAR_H LED pixels over valid/ready to the WS2812B driver. Character and color ROMs stay external and are read combinationally through address/data ports.

## Interface
- NUM_CHARS, 4, characters per frame (≥1)
- BUF_DEPTH, 8, ring-buffer entries; power of 2, ≥ NUM_CHARS
- CHAR_W, 5, glyph columns
- CHAR_H, 7, glyph rows
- COLOR_BITS, 4, color-ROM address width
- REFRESH_CYCLES, 262144, clk cycles per refresh tick
- SCROLL_DIV, 16, frames per marquee step
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts byte; transfer on rx_valid&rx_ready
- rnd_color  in  COLOR_BITS  random color index, sampled on accept
- char_addr  out  8  character-ROM address
- char_data  in  CHAR_W*CHAR_H  glyph bits, bit k = LED k of glyph
- color_addr  out  COLOR_BITS  color-ROM address
- color_data  in  24  GRB color
- pix_data  out  24  pixel color
- pix_valid  out  1  pixel offered
- pix_ready  in  1  driver accepts; transfer on pix_valid&pix_ready
- pix_latch  out  1  high with the last pixel of a frame
- busy  out  1  frame render in progress

## Operation
- Reset, asynchronous on rst_n low, applies these values:
  - All buffer chars = 0x20 and colors = 0.
  - wr_ptr=0, count=0, scroll_off=0.
  - Color mode = random, scroll mode = off.
  - rx_ready, pix_valid, pix_latch, busy = 0. pix_data, char_addr, color_addr = 0.
  - Refresh and frame counters = 0.
- Write side: rx_ready rises on the first clk after reset release. It stays high except during CLEAR.
- Accepted byte classes:
  - 0x00: clear. Enter CLEAR, which writes 0x20/color 0 to one entry per cycle for BUF_DEPTH cycles with rx_ready=0. Then wr_ptr=0, count=0, scroll_off=0.
  - 0x01: color mode = random.
  - 0x10–0x1F: color mode = fixed, index = byte[COLOR_BITS-1:0], zero-extended or truncated.
  - 0x02: toggle scroll mode and reset scroll_off to 0.
  - Other bytes < 0x20: consumed, no effect.
  - Bytes ≥ 0x20: buf[wr_ptr] ← byte, with color = rnd_color or the fixed index. wr_ptr wraps mod BUF_DEPTH. count saturates at BUF_DEPTH.
- Window base, latched at frame start:
  - Scroll off: base = (wr_ptr − NUM_CHARS) mod BUF_DEPTH, so the newest character sits at the last position.
  - Scroll on: base = (wr_ptr − count + scroll_off) mod BUF_DEPTH.
- Character p reads slot (base+p) mod BUF_DEPTH.
- scroll_off increments every SCROLL_DIV completed frames, mod count. It is held at 0 while count ≤ NUM_CHARS.
- Render FSM: IDLE → LOAD → SEND → (LOAD | IDLE).
  - IDLE: wait for refresh tick.
  - LOAD: drive char_addr/color_addr for the current character and LED.
  - SEND: pix_valid=1, pix_data = char_data[led] ? color_data : 0. Hold until pix_ready.
- Pixel order: character 0..NUM_CHARS-1, and LED 0..CHAR_W*CHAR_H-1 within each character.
- pix_data is 0 whenever pix_valid=0.

## Timing
- Refresh tick fires when the refresh counter reaches REFRESH_CYCLES-1; the counter then wraps. A tick arriving while busy is dropped; there is no queued frame.
- Tick to first pix_valid: 2 cycles, through IDLE→LOAD→SEND.
- Each pixel takes ≥2 cycles. After a transfer, the next pix_valid comes 2 cycles later.
- pix_valid, pix_data and pix_latch are stable until transfer.
- busy is high from LOAD of pixel 0 through the cycle after the last transfer.
- Frame-end FSM goes to IDLE, increments the frame counter and updates scroll_off.
- A byte accepted in the same cycle as frame start does not affect that frame's base. Writes during a frame may change characters not yet loaded.
- A clear arriving mid-frame runs concurrently; the frame is not aborted.
- rst_n asserted mid-frame or mid-CLEAR drops pix_valid/rx_ready immediately, with no latch pulse.

## Test plan
- Reset, then send "ABCD" with rnd_color=3 → next frame: 140 pixels; pixels 0–34 use glyph 0x41, color_addr=3; pix_latch only on pixel 139.
- Send 0x15 then "WXYZ" → color_addr=5 for all four characters; send 0x01 and "Q" → Q takes the rnd_color value.
- Send 10 characters "0123456789", scroll off → window shows "6789"; wr_ptr=2, count=8.
- Send 0x02 with 8 characters buffered, SCROLL_DIV=2 → window base advances by one every 2 frames and wraps after 8 steps.
- Send 0x00 → rx_ready low for exactly BUF_DEPTH cycles; next frame shows all spaces (0x20); a byte offered during CLEAR is not accepted.
- Hold pix_ready low 50 cycles mid-frame → pix_valid/pix_data held stable, a refresh tick during the stall is dropped, and the frame completes intact.
